reorder_buffer: RTL and testbench

In-order completion tracker at the consumer end of the M/WB pipeline register. Allocates a 7-bit `rob_id` per instruction at dispatch, absorbs the writeback bundle (result, exception, faulting address) tagged with that `rob_id`, and retires entries strictly in allocation order. An excepting instruction is retired with a flush that empties the buffer.

---
 rtl/reorder_buffer_if.sv | 45 ++++
 rtl/reorder_buffer.sv | 125 ++++++++++++
 tb/tb_reorder_buffer.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_if.sv
// Dispatch, writeback and retire signals of the reorder buffer; ids are always 7 bits wide.
// master = dispatch/writeback side, slave = the reorder buffer itself.
interface reorder_buffer_if #(
    parameter int WORD_SIZE = 32
);
    logic                 alloc_valid;
    logic [1:0]           alloc_instruction_type;
    logic [WORD_SIZE-1:0] alloc_pc;
    logic                 alloc_ready;
    logic [6:0]           alloc_rob_id;

    logic                 wb_valid;
    logic [6:0]           wb_rob_id;
    logic [WORD_SIZE-1:0] wb_result;
    logic                 wb_exception;
    logic [WORD_SIZE-1:0] wb_virtual_addr_exception;

    logic                 commit_valid;
    logic [6:0]           commit_rob_id;
    logic [1:0]           commit_instruction_type;
    logic [WORD_SIZE-1:0] commit_pc;
    logic [WORD_SIZE-1:0] commit_result;
    logic                 commit_exception;
    logic [WORD_SIZE-1:0] commit_virtual_addr_exception;
    logic                 flush;
    logic [6:0]           count;

    modport master (
        output alloc_valid, alloc_instruction_type, alloc_pc,
        input  alloc_ready, alloc_rob_id,
        output wb_valid, wb_rob_id, wb_result, wb_exception, wb_virtual_addr_exception,
        input  commit_valid, commit_rob_id, commit_instruction_type, commit_pc,
        input  commit_result, commit_exception, commit_virtual_addr_exception,
        input  flush, count
    );

    modport slave (
        input  alloc_valid, alloc_instruction_type, alloc_pc,
        output alloc_ready, alloc_rob_id,
        input  wb_valid, wb_rob_id, wb_result, wb_exception, wb_virtual_addr_exception,
        output commit_valid, commit_rob_id, commit_instruction_type, commit_pc,
        output commit_result, commit_exception, commit_virtual_addr_exception,
        output flush, count
    );
endinterface

// File: rtl/reorder_buffer.sv
// In-order completion tracker: id granted combinationally at dispatch, retire one cycle after writeback.
// No retire back-pressure; dispatch stalls only when full or during an excepting (flushing) commit.
module reorder_buffer #(
    parameter int WORD_SIZE   = 32,
    parameter int ROB_ENTRIES = 8
) (
    input  logic            clk,
    input  logic            reset,
    reorder_buffer_if.slave rob
);
    localparam int         PTR_W     = $clog2(ROB_ENTRIES);
    localparam logic [6:0] ENTRIES_C = 7'(ROB_ENTRIES);

    typedef logic [PTR_W-1:0] ptr_t;

    typedef struct packed {
        logic [1:0]           itype;
        logic [WORD_SIZE-1:0] pc;
        logic [WORD_SIZE-1:0] result;
        logic                 exc;
        logic [WORD_SIZE-1:0] vaddr;
    } entry_t;

    entry_t                 entry_q [ROB_ENTRIES];
    logic [ROB_ENTRIES-1:0] busy_q, busy_d;
    logic [ROB_ENTRIES-1:0] done_q, done_d;
    ptr_t                   head_q, head_d;
    ptr_t                   tail_q, tail_d;
    logic [6:0]             count_q, count_d;

    ptr_t wb_idx;
    logic wb_in_range;
    logic commit_vld;
    logic flush_vld;
    logic alloc_rdy;
    logic alloc_fire;
    logic wb_fire;

    assign wb_idx      = rob.wb_rob_id[PTR_W-1:0];
    assign wb_in_range = rob.wb_rob_id < ENTRIES_C;
    assign commit_vld  = busy_q[head_q] && done_q[head_q];
    assign flush_vld   = commit_vld && entry_q[head_q].exc;
    assign alloc_rdy   = (count_q < ENTRIES_C) && !flush_vld;
    assign alloc_fire  = rob.alloc_valid && alloc_rdy;
    // A writeback racing the retire of its own entry is dropped so the freed slot stays clean.
    assign wb_fire     = rob.wb_valid && wb_in_range && busy_q[wb_idx] && !flush_vld
                         && !(commit_vld && (wb_idx == head_q));

    always_comb begin
        busy_d  = busy_q;
        done_d  = done_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_vld) begin
            busy_d  = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (wb_fire) begin
                done_d[wb_idx] = 1'b1;
            end
            if (commit_vld) begin
                busy_d[head_q] = 1'b0;
                done_d[head_q] = 1'b0;
                head_d         = head_q + 1'b1;
            end
            if (alloc_fire) begin
                busy_d[tail_q] = 1'b1;
                done_d[tail_q] = 1'b0;
                tail_d         = tail_q + 1'b1;
            end
            count_d = count_q + {6'd0, alloc_fire} - {6'd0, commit_vld};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q  <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            done_q  <= done_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload is only written on a handshake; stale fields are masked by busy/done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ROB_ENTRIES; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            if (alloc_fire) begin
                entry_q[tail_q].itype <= rob.alloc_instruction_type;
                entry_q[tail_q].pc    <= rob.alloc_pc;
            end
            if (wb_fire) begin
                entry_q[wb_idx].result <= rob.wb_result;
                entry_q[wb_idx].exc    <= rob.wb_exception;
                entry_q[wb_idx].vaddr  <= rob.wb_virtual_addr_exception;
            end
        end
    end

    assign rob.alloc_ready                   = alloc_rdy;
    assign rob.alloc_rob_id                  = {{(7-PTR_W){1'b0}}, tail_q};
    assign rob.commit_valid                  = commit_vld;
    assign rob.commit_rob_id                 = {{(7-PTR_W){1'b0}}, head_q};
    assign rob.commit_instruction_type       = entry_q[head_q].itype;
    assign rob.commit_pc                     = entry_q[head_q].pc;
    assign rob.commit_result                 = entry_q[head_q].result;
    assign rob.commit_exception              = entry_q[head_q].exc;
    assign rob.commit_virtual_addr_exception = entry_q[head_q].vaddr;
    assign rob.flush                         = flush_vld;
    assign rob.count                         = count_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed cycle table, hand sequences, random vs queue model.
module tb_reorder_buffer;
    localparam int N  = 8;
    localparam int NV = 21;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    reorder_buffer_if #(.WORD_SIZE(32)) rif ();

    reorder_buffer #(.WORD_SIZE(32), .ROB_ENTRIES(N)) dut (
        .clk   (clk),
        .reset (reset),
        .rob   (rif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    typedef struct {
        logic        av;
        logic [31:0] apc;
        logic        wv;
        logic [6:0]  wid;
        logic [31:0] wres;
        logic        wexc;
        logic [31:0] wva;
        logic        e_rdy;
        logic [6:0]  e_id;
        logic        e_cv;
        logic [6:0]  e_cid;
        logic [31:0] e_pc;
        logic [31:0] e_res;
        logic        e_fl;
        logic [6:0]  e_cnt;
    } vec_t;

    typedef struct {
        int          id;
        logic [1:0]  typ;
        logic [31:0] pc;
        logic        done;
        logic [31:0] res;
        logic        exc;
        logic [31:0] va;
    } mentry_t;

    vec_t    vec [NV];
    mentry_t q [$];

    function automatic vec_t mk(input logic [31:0] av, apc, wv, wid, wres, wexc, wva,
                                input logic [31:0] rdy, id, cv, cid, pc, res, fl, cnt);
        vec_t v;
        v.av = av[0];   v.apc = apc;   v.wv = wv[0];   v.wid = wid[6:0];
        v.wres = wres;  v.wexc = wexc[0]; v.wva = wva;
        v.e_rdy = rdy[0]; v.e_id = id[6:0]; v.e_cv = cv[0]; v.e_cid = cid[6:0];
        v.e_pc = pc; v.e_res = res; v.e_fl = fl[0]; v.e_cnt = cnt[6:0];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [1:0] typ, input logic [31:0] apc,
                         input logic wv, input logic [6:0] wid, input logic [31:0] wres,
                         input logic wexc, input logic [31:0] wva);
        rif.alloc_valid               = av;
        rif.alloc_instruction_type    = typ;
        rif.alloc_pc                  = apc;
        rif.wb_valid                  = wv;
        rif.wb_rob_id                 = wid;
        rif.wb_result                 = wres;
        rif.wb_exception              = wexc;
        rif.wb_virtual_addr_exception = wva;
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, 32'd0, 1'b0, 7'd0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b1;
        idle();

        // Directed cycle table: inputs for the cycle, outputs expected before its edge.
        //            av apc      wv wid wres wexc wva            rdy id cv cid pc     res  fl cnt
        vec[0]  = mk(1, 32'h100, 0, 0, 0,    0, 0,             1, 0, 0, 0, 0,     0,    0, 0);
        vec[1]  = mk(1, 32'h104, 0, 0, 0,    0, 0,             1, 1, 0, 0, 0,     0,    0, 1);
        vec[2]  = mk(1, 32'h108, 0, 0, 0,    0, 0,             1, 2, 0, 0, 0,     0,    0, 2);
        vec[3]  = mk(0, 0,       1, 2, 32'hC, 0, 0,            1, 3, 0, 0, 0,     0,    0, 3);
        vec[4]  = mk(0, 0,       1, 1, 32'hB, 0, 0,            1, 3, 0, 0, 0,     0,    0, 3);
        vec[5]  = mk(0, 0,       1, 0, 32'hA, 0, 0,            1, 3, 0, 0, 0,     0,    0, 3);
        vec[6]  = mk(0, 0,       0, 0, 0,    0, 0,             1, 3, 1, 0, 32'h100, 32'hA, 0, 3);
        vec[7]  = mk(0, 0,       0, 0, 0,    0, 0,             1, 3, 1, 1, 32'h104, 32'hB, 0, 2);
        vec[8]  = mk(0, 0,       0, 0, 0,    0, 0,             1, 3, 1, 2, 32'h108, 32'hC, 0, 1);
        vec[9]  = mk(1, 32'h200, 0, 0, 0,    0, 0,             1, 3, 0, 0, 0,     0,    0, 0);
        vec[10] = mk(1, 32'h204, 0, 0, 0,    0, 0,             1, 4, 0, 0, 0,     0,    0, 1);
        vec[11] = mk(1, 32'h208, 0, 0, 0,    0, 0,             1, 5, 0, 0, 0,     0,    0, 2);
        vec[12] = mk(1, 32'h20C, 0, 0, 0,    0, 0,             1, 6, 0, 0, 0,     0,    0, 3);
        vec[13] = mk(0, 0,       1, 4, 32'h44, 1, 32'hDEAD0000, 1, 7, 0, 0, 0,   0,    0, 4);
        vec[14] = mk(0, 0,       1, 3, 32'h33, 0, 0,           1, 7, 0, 0, 0,     0,    0, 4);
        vec[15] = mk(0, 0,       0, 0, 0,    0, 0,             1, 7, 1, 3, 32'h200, 32'h33, 0, 4);
        vec[16] = mk(1, 32'h300, 1, 5, 32'h55, 0, 0,           0, 7, 1, 4, 32'h204, 32'h44, 1, 3);
        vec[17] = mk(0, 0,       0, 0, 0,    0, 0,             1, 0, 0, 0, 0,     0,    0, 0);
        vec[18] = mk(0, 0,       1, 5, 32'h99, 0, 0,           1, 0, 0, 0, 0,     0,    0, 0);
        vec[19] = mk(0, 0,       1, 9, 32'h77, 0, 0,           1, 0, 0, 0, 0,     0,    0, 0);
        vec[20] = mk(0, 0,       0, 0, 0,    0, 0,             1, 0, 0, 0, 0,     0,    0, 0);

        // Reset values while reset is held.
        #3;
        chk("rst alloc_ready", 32'(rif.alloc_ready), 32'd1);
        chk("rst alloc_rob_id", 32'(rif.alloc_rob_id), 32'd0);
        chk("rst commit_valid", 32'(rif.commit_valid), 32'd0);
        chk("rst flush", 32'(rif.flush), 32'd0);
        chk("rst count", 32'(rif.count), 32'd0);
        chk("rst commit_pc", rif.commit_pc, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        for (int i = 0; i < NV; i++) begin
            drive(vec[i].av, vec[i].apc[3:2], vec[i].apc, vec[i].wv, vec[i].wid,
                  vec[i].wres, vec[i].wexc, vec[i].wva);
            @(negedge clk);
            chk($sformatf("vec%0d alloc_ready", i), 32'(rif.alloc_ready), 32'(vec[i].e_rdy));
            chk($sformatf("vec%0d alloc_rob_id", i), 32'(rif.alloc_rob_id), 32'(vec[i].e_id));
            chk($sformatf("vec%0d commit_valid", i), 32'(rif.commit_valid), 32'(vec[i].e_cv));
            chk($sformatf("vec%0d flush", i), 32'(rif.flush), 32'(vec[i].e_fl));
            chk($sformatf("vec%0d count", i), 32'(rif.count), 32'(vec[i].e_cnt));
            if (vec[i].e_cv) begin
                chk($sformatf("vec%0d commit_rob_id", i), 32'(rif.commit_rob_id), 32'(vec[i].e_cid));
                chk($sformatf("vec%0d commit_pc", i), rif.commit_pc, vec[i].e_pc);
                chk($sformatf("vec%0d commit_result", i), rif.commit_result, vec[i].e_res);
            end
            if (vec[i].e_fl) begin
                chk("flush commit_vaddr", rif.commit_virtual_addr_exception, 32'hDEAD0000);
            end
            tick();
        end

        // Full buffer, retire while full does not free a slot that cycle, then wrap to id 0.
        for (int i = 0; i < N; i++) begin
            drive(1'b1, 2'd1, 32'h400 + 32'(4 * i), 1'b0, 7'd0, 32'd0, 1'b0, 32'd0);
            @(negedge clk);
            chk($sformatf("fill%0d alloc_rob_id", i), 32'(rif.alloc_rob_id), 32'(i));
            tick();
        end
        drive(1'b0, 2'd0, 32'd0, 1'b1, 7'd0, 32'h1, 1'b0, 32'd0);
        @(negedge clk);
        chk("full alloc_ready", 32'(rif.alloc_ready), 32'd0);
        chk("full count", 32'(rif.count), 32'd8);
        tick();
        drive(1'b1, 2'd2, 32'h500, 1'b0, 7'd0, 32'd0, 1'b0, 32'd0);
        @(negedge clk);
        chk("full+commit alloc_ready", 32'(rif.alloc_ready), 32'd0);
        chk("full+commit commit_valid", 32'(rif.commit_valid), 32'd1);
        chk("full+commit commit_rob_id", 32'(rif.commit_rob_id), 32'd0);
        tick();
        @(negedge clk);
        chk("wrap alloc_ready", 32'(rif.alloc_ready), 32'd1);
        chk("wrap alloc_rob_id", 32'(rif.alloc_rob_id), 32'd0);
        chk("wrap count", 32'(rif.count), 32'd7);
        tick();
        idle();
        @(negedge clk);
        chk("wrap refill count", 32'(rif.count), 32'd8);
        tick();

        // Asynchronous reset in the middle of a cycle with a retire pending.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'd3, 32'h600 + 32'(4 * i), 1'b0, 7'd0, 32'd0, 1'b0, 32'd0);
            tick();
        end
        drive(1'b0, 2'd0, 32'd0, 1'b1, 7'd0, 32'h66, 1'b0, 32'd0);
        tick();
        idle();
        @(negedge clk);
        chk("pre-reset commit_valid", 32'(rif.commit_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst commit_valid", 32'(rif.commit_valid), 32'd0);
        chk("midrst count", 32'(rif.count), 32'd0);
        chk("midrst alloc_ready", 32'(rif.alloc_ready), 32'd1);
        chk("midrst alloc_rob_id", 32'(rif.alloc_rob_id), 32'd0);
        chk("midrst commit_result", rif.commit_result, 32'd0);
        tick();
        #2;
        reset = 1'b0;
        drive(1'b1, 2'd0, 32'h700, 1'b0, 7'd0, 32'd0, 1'b0, 32'd0);
        @(negedge clk);
        chk("post-reset alloc_rob_id", 32'(rif.alloc_rob_id), 32'd0);
        tick();
        idle();
        @(negedge clk);
        chk("post-reset count", 32'(rif.count), 32'd1);
        tick();

        // Random traffic against an in-order queue model.
        do_reset();
        q.delete();
        begin
            int          nid;
            logic        av, wv, wexc, cv, fl, rdy;
            logic [1:0]  typ;
            logic [31:0] apc, wres, wva;
            logic [6:0]  wid;
            mentry_t     e;
            nid = 0;
            for (int c = 0; c < 2000; c++) begin
                av   = ($urandom_range(0, 9) < 7);
                wv   = ($urandom_range(0, 9) < 6);
                typ  = 2'($urandom_range(0, 3));
                apc  = $urandom;
                wres = $urandom;
                wva  = $urandom;
                wexc = ($urandom_range(0, 19) == 0);
                if (q.size() > 0 && $urandom_range(0, 9) < 8)
                    wid = 7'(q[$urandom_range(0, q.size() - 1)].id);
                else
                    wid = 7'($urandom_range(0, 9));
                drive(av, typ, apc, wv, wid, wres, wexc, wva);

                cv  = (q.size() > 0) && q[0].done;
                fl  = cv && q[0].exc;
                rdy = (q.size() < N) && !fl;
                @(negedge clk);
                chk($sformatf("rnd%0d alloc_ready", c), 32'(rif.alloc_ready), 32'(rdy));
                chk($sformatf("rnd%0d alloc_rob_id", c), 32'(rif.alloc_rob_id), 32'(nid));
                chk($sformatf("rnd%0d commit_valid", c), 32'(rif.commit_valid), 32'(cv));
                chk($sformatf("rnd%0d flush", c), 32'(rif.flush), 32'(fl));
                chk($sformatf("rnd%0d count", c), 32'(rif.count), 32'(q.size()));
                if (cv) begin
                    chk($sformatf("rnd%0d commit_rob_id", c), 32'(rif.commit_rob_id), 32'(q[0].id));
                    chk($sformatf("rnd%0d commit_type", c), 32'(rif.commit_instruction_type), 32'(q[0].typ));
                    chk($sformatf("rnd%0d commit_pc", c), rif.commit_pc, q[0].pc);
                    chk($sformatf("rnd%0d commit_result", c), rif.commit_result, q[0].res);
                    chk($sformatf("rnd%0d commit_exc", c), 32'(rif.commit_exception), 32'(q[0].exc));
                    chk($sformatf("rnd%0d commit_vaddr", c), rif.commit_virtual_addr_exception, q[0].va);
                end

                if (fl) begin
                    q.delete();
                    nid = 0;
                end else begin
                    if (wv) begin
                        for (int k = 0; k < q.size(); k++) begin
                            if (q[k].id == int'(wid) && !(cv && k == 0)) begin
                                e      = q[k];
                                e.done = 1'b1;
                                e.res  = wres;
                                e.exc  = wexc;
                                e.va   = wva;
                                q[k]   = e;
                            end
                        end
                    end
                    if (cv) void'(q.pop_front());
                    if (av && rdy) begin
                        e.id   = nid;
                        e.typ  = typ;
                        e.pc   = apc;
                        e.done = 1'b0;
                        e.res  = 32'd0;
                        e.exc  = 1'b0;
                        e.va   = 32'd0;
                        q.push_back(e);
                        nid = (nid + 1) % N;
                    end
                end
                tick();
            end
        end

        idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
